// File: rtl/fb_pkg.sv
// Shared types and default sizes for the framebuffer port arbiter.
// Optional starvation guard is enabled by defining FB_STARVE_GUARD_EN.
package fb_pkg;

    localparam int FB_AW_DEF    = 13;
    localparam int FB_DW_DEF    = 8;
    localparam int FB_DEPTH_DEF = 6400;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_VID,
        GRANT_WR,
        GRANT_RD
    } grant_e;

    // What the RAM will be returning on the cycle after a grant.
    // miss marks a video slot that the starvation guard handed to a host.
    typedef struct packed {
        logic was_vid;
        logic was_hrd;
        logic oob;
        logic miss;
    } rd_tag_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Bus bundle between the video scan-out, host ports, arbiter and framebuffer RAM.
// The requesters and RAM model sit on the master side, the arbiter on the slave side.
// Used by fb_port_arbiter (starvation guard macro: FB_STARVE_GUARD_EN).
interface fb_port_arbiter_if
    import fb_pkg::*;
#(
    parameter int AW = FB_AW_DEF,
    parameter int DW = FB_DW_DEF
) ();

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          vid_miss;

    logic          hwr_valid;
    logic          hwr_ready;
    logic [AW-1:0] hwr_addr;
    logic [DW-1:0] hwr_data;

    logic          hrd_valid;
    logic          hrd_ready;
    logic [AW-1:0] hrd_addr;
    logic [DW-1:0] hrd_data;
    logic          hrd_data_valid;

    logic          oob_err;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport master (
        output vid_req, vid_addr, hwr_valid, hwr_addr, hwr_data,
               hrd_valid, hrd_addr, ram_rdata,
        input  vid_data, vid_valid, vid_miss, hwr_ready, hrd_ready,
               hrd_data, hrd_data_valid, oob_err, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  vid_req, vid_addr, hwr_valid, hwr_addr, hwr_data,
               hrd_valid, hrd_addr, ram_rdata,
        output vid_data, vid_valid, vid_miss, hwr_ready, hrd_ready,
               hrd_data, hrd_data_valid, oob_err, ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/fb_rr_pick.sv
// Two-way round-robin choice between the host write and host read ports.
// The pointer names the port that wins when both are pending; after a host
// grant it points at the port that was not served.
module fb_rr_pick
    import fb_pkg::*;
(
    input  logic   clk25,
    input  logic   rst_n,
    input  logic   req_wr,
    input  logic   req_rd,
    input  grant_e granted,
    output grant_e pick
);

    logic ptr_rd;

    // Host choice for this cycle; a lone request always wins.
    always_comb begin
        pick = GRANT_NONE;
        if (req_wr && req_rd) begin
            pick = ptr_rd ? GRANT_RD : GRANT_WR;
        end else if (req_wr) begin
            pick = GRANT_WR;
        end else if (req_rd) begin
            pick = GRANT_RD;
        end
    end

    // Point away from whichever host port was just served.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            ptr_rd <= 1'b0;
        end else if (granted == GRANT_WR) begin
            ptr_rd <= 1'b1;
        end else if (granted == GRANT_RD) begin
            ptr_rd <= 1'b0;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: video scan-out has fixed priority, the two
// host ports share the remaining cycles round-robin. Reads return 2 cycles
// after grant. Define FB_STARVE_GUARD_EN to let a host that has waited
// MAX_WAIT cycles take a video slot (video then sees vid_miss).
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int AW       = FB_AW_DEF,
    parameter int DW       = FB_DW_DEF,
    parameter int FB_DEPTH = FB_DEPTH_DEF
`ifdef FB_STARVE_GUARD_EN
    ,
    parameter int MAX_WAIT = 15
`endif
) (
    input  logic             clk25,
    input  logic             rst_n,
    fb_port_arbiter_if.slave bus
);

    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(FB_DEPTH);

    grant_e        host_pick;
    grant_e        grant_p0;
    logic          host_pend;
    logic          starve;
    logic          vid_miss_p0;
    logic          oob_p0;
    logic [AW-1:0] addr_p0;
    logic [AW-1:0] addr_hold;
    logic          oob_err_q;
    rd_tag_t       tag_p1;
    logic          vid_vld_p2;
    logic          vid_miss_p2;
    logic [DW-1:0] vid_data_p2;
    logic          hrd_vld_p2;
    logic [DW-1:0] hrd_data_p2;

    assign host_pend = bus.hwr_valid || bus.hrd_valid;

    fb_rr_pick u_rr_pick (
        .clk25   (clk25),
        .rst_n   (rst_n),
        .req_wr  (bus.hwr_valid),
        .req_rd  (bus.hrd_valid),
        .granted (grant_p0),
        .pick    (host_pick)
    );

`ifdef FB_STARVE_GUARD_EN
    logic [3:0] wait_cnt;

    assign starve = host_pend && (wait_cnt == 4'(MAX_WAIT));

    // Count cycles a host request sits unserved; any host grant restarts it.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (grant_p0 == GRANT_WR || grant_p0 == GRANT_RD) begin
            wait_cnt <= '0;
        end else if (host_pend) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    assign starve = 1'b0;
`endif

    // Stage p0: pick one requester; nothing is granted while reset is asserted.
    always_comb begin
        grant_p0    = GRANT_NONE;
        vid_miss_p0 = 1'b0;
        if (rst_n) begin
            if (bus.vid_req && !starve) begin
                grant_p0 = GRANT_VID;
            end else if (host_pend) begin
                grant_p0    = host_pick;
                vid_miss_p0 = bus.vid_req;
            end
        end
    end

    // RAM address follows the winner and holds its last value when idle.
    always_comb begin
        addr_p0 = addr_hold;
        case (grant_p0)
            GRANT_VID: addr_p0 = bus.vid_addr;
            GRANT_WR:  addr_p0 = bus.hwr_addr;
            GRANT_RD:  addr_p0 = bus.hrd_addr;
            default:   addr_p0 = addr_hold;
        endcase
    end

    assign oob_p0        = (grant_p0 != GRANT_NONE) && ({1'b0, addr_p0} >= DEPTH_LIM);
    assign bus.ram_addr  = addr_p0;
    assign bus.ram_we    = (grant_p0 == GRANT_WR) && !oob_p0;
    assign bus.ram_wdata = (grant_p0 == GRANT_WR) ? bus.hwr_data : '0;
    assign bus.hwr_ready = (grant_p0 == GRANT_WR);
    assign bus.hrd_ready = (grant_p0 == GRANT_RD);

    // Stage p0 -> p1: tag what the RAM returns next cycle, track sticky OOB.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            tag_p1    <= '0;
            addr_hold <= '0;
            oob_err_q <= 1'b0;
        end else begin
            tag_p1.was_vid <= (grant_p0 == GRANT_VID) || vid_miss_p0;
            tag_p1.was_hrd <= (grant_p0 == GRANT_RD);
            tag_p1.oob     <= oob_p0;
            tag_p1.miss    <= vid_miss_p0;
            addr_hold      <= addr_p0;
            if (oob_p0) begin
                oob_err_q <= 1'b1;
            end
        end
    end

    // Stage p1 -> p2: register read data; OOB reads return zero, missed video keeps old data.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            vid_vld_p2  <= 1'b0;
            vid_miss_p2 <= 1'b0;
            vid_data_p2 <= '0;
            hrd_vld_p2  <= 1'b0;
            hrd_data_p2 <= '0;
        end else begin
            vid_vld_p2  <= tag_p1.was_vid;
            vid_miss_p2 <= tag_p1.was_vid && tag_p1.miss;
            hrd_vld_p2  <= tag_p1.was_hrd;
            if (tag_p1.was_vid && !tag_p1.miss) begin
                vid_data_p2 <= tag_p1.oob ? '0 : bus.ram_rdata;
            end
            if (tag_p1.was_hrd) begin
                hrd_data_p2 <= tag_p1.oob ? '0 : bus.ram_rdata;
            end
        end
    end

    assign bus.vid_valid      = vid_vld_p2;
    assign bus.vid_miss       = vid_miss_p2;
    assign bus.vid_data       = vid_data_p2;
    assign bus.hrd_data_valid = hrd_vld_p2;
    assign bus.hrd_data       = hrd_data_p2;
    assign bus.oob_err        = oob_err_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: a vector table of per-cycle inputs and
// expected outputs, plus sequences for reset during a read and the
// starvation guard (expectations follow FB_STARVE_GUARD_EN).
module tb_fb_port_arbiter;

    logic clk25 = 1'b0;
    logic rst_n;

    fb_port_arbiter_if #(.AW(13), .DW(8)) bus ();

    fb_port_arbiter dut (
        .clk25 (clk25),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #20 clk25 = ~clk25;

    // Framebuffer RAM model: 1-cycle read latency, preloaded with mem[a]=a, mem[10]=0x11.
    logic [7:0] mem [0:8191];
    logic       mem_init = 1'b0;

    always @(posedge clk25) begin
        if (!mem_init) begin
            for (int a = 0; a < 8192; a++) begin
                mem[a] <= (a == 10) ? 8'h11 : 8'(a);
            end
            mem_init <= 1'b1;
        end else begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

`ifdef FB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        vr;
        logic [12:0] va;
        logic        wv;
        logic [12:0] wa;
        logic [7:0]  wd;
        logic        rv;
        logic [12:0] ra;
        logic        e_wrdy;
        logic        e_rrdy;
        logic        e_we;
        logic        e_vv;
        logic [7:0]  e_vd;
        logic        e_hv;
        logic [7:0]  e_hd;
        logic        e_oob;
    } vec_t;

    function automatic vec_t mk(
        input logic vr, input logic [12:0] va,
        input logic wv, input logic [12:0] wa, input logic [7:0] wd,
        input logic rv, input logic [12:0] ra,
        input logic e_wrdy, input logic e_rrdy, input logic e_we,
        input logic e_vv, input logic [7:0] e_vd,
        input logic e_hv, input logic [7:0] e_hd, input logic e_oob);
        vec_t v;
        v.vr = vr; v.va = va; v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra;
        v.e_wrdy = e_wrdy; v.e_rrdy = e_rrdy; v.e_we = e_we;
        v.e_vv = e_vv; v.e_vd = e_vd; v.e_hv = e_hv; v.e_hd = e_hd; v.e_oob = e_oob;
        return v;
    endfunction

    task automatic set_inputs(input logic vr, input logic [12:0] va,
                              input logic wv, input logic [12:0] wa, input logic [7:0] wd,
                              input logic rv, input logic [12:0] ra);
        bus.vid_req   = vr;
        bus.vid_addr  = va;
        bus.hwr_valid = wv;
        bus.hwr_addr  = wa;
        bus.hwr_data  = wd;
        bus.hrd_valid = rv;
        bus.hrd_addr  = ra;
    endtask

    task automatic next_cycle();
        @(posedge clk25);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " vid_data"},       32'(bus.vid_data), 0);
        chk({tag, " vid_valid"},      32'(bus.vid_valid), 0);
        chk({tag, " vid_miss"},       32'(bus.vid_miss), 0);
        chk({tag, " hwr_ready"},      32'(bus.hwr_ready), 0);
        chk({tag, " hrd_ready"},      32'(bus.hrd_ready), 0);
        chk({tag, " hrd_data"},       32'(bus.hrd_data), 0);
        chk({tag, " hrd_data_valid"}, 32'(bus.hrd_data_valid), 0);
        chk({tag, " oob_err"},        32'(bus.oob_err), 0);
        chk({tag, " ram_addr"},       32'(bus.ram_addr), 0);
        chk({tag, " ram_we"},         32'(bus.ram_we), 0);
        chk({tag, " ram_wdata"},      32'(bus.ram_wdata), 0);
    endtask

    localparam int NV = 27;
    vec_t tbl [NV];

    initial begin
        // Rows: inputs (vr va | wv wa wd | rv ra), expected (wrdy rrdy we | vv vd | hv hd | oob).
        tbl[0]  = mk(1, 0,    0, 0,    8'h00, 0, 0,    0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
        tbl[1]  = mk(1, 1,    0, 0,    8'h00, 0, 0,    0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
        tbl[2]  = mk(1, 2,    0, 0,    8'h00, 0, 0,    0, 0, 0, 1, 8'h00, 0, 8'h00, 0);
        tbl[3]  = mk(1, 3,    0, 0,    8'h00, 0, 0,    0, 0, 0, 1, 8'h01, 0, 8'h00, 0);
        tbl[4]  = mk(0, 0,    0, 0,    8'h00, 0, 0,    0, 0, 0, 1, 8'h02, 0, 8'h00, 0);
        tbl[5]  = mk(0, 0,    0, 0,    8'h00, 0, 0,    0, 0, 0, 1, 8'h03, 0, 8'h00, 0);
        tbl[6]  = mk(0, 0,    0, 0,    8'h00, 0, 0,    0, 0, 0, 0, 8'h03, 0, 8'h00, 0);
        tbl[7]  = mk(0, 0,    1, 20,   8'hA0, 1, 20,   1, 0, 1, 0, 8'h03, 0, 8'h00, 0);
        tbl[8]  = mk(0, 0,    1, 21,   8'hA1, 1, 20,   0, 1, 0, 0, 8'h03, 0, 8'h00, 0);
        tbl[9]  = mk(0, 0,    1, 21,   8'hA1, 1, 21,   1, 0, 1, 0, 8'h03, 0, 8'h00, 0);
        tbl[10] = mk(0, 0,    1, 22,   8'hA2, 1, 21,   0, 1, 0, 0, 8'h03, 1, 8'hA0, 0);
        tbl[11] = mk(0, 0,    1, 22,   8'hA2, 1, 5,    1, 0, 1, 0, 8'h03, 0, 8'hA0, 0);
        tbl[12] = mk(0, 0,    0, 0,    8'h00, 1, 5,    0, 1, 0, 0, 8'h03, 1, 8'hA1, 0);
        tbl[13] = mk(0, 0,    0, 0,    8'h00, 0, 0,    0, 0, 0, 0, 8'h03, 0, 8'hA1, 0);
        tbl[14] = mk(0, 0,    0, 0,    8'h00, 0, 0,    0, 0, 0, 0, 8'h03, 1, 8'h05, 0);
        tbl[15] = mk(0, 0,    0, 0,    8'h00, 1, 10,   0, 1, 0, 0, 8'h03, 0, 8'h05, 0);
        tbl[16] = mk(0, 0,    1, 10,   8'h3C, 0, 0,    1, 0, 1, 0, 8'h03, 0, 8'h05, 0);
        tbl[17] = mk(0, 0,    0, 0,    8'h00, 1, 10,   0, 1, 0, 0, 8'h03, 1, 8'h11, 0);
        tbl[18] = mk(0, 0,    0, 0,    8'h00, 0, 0,    0, 0, 0, 0, 8'h03, 0, 8'h11, 0);
        tbl[19] = mk(0, 0,    0, 0,    8'h00, 0, 0,    0, 0, 0, 0, 8'h03, 1, 8'h3C, 0);
        tbl[20] = mk(1, 4,    1, 30,   8'h55, 0, 0,    0, 0, 0, 0, 8'h03, 0, 8'h3C, 0);
        tbl[21] = mk(0, 0,    1, 30,   8'h55, 0, 0,    1, 0, 1, 0, 8'h03, 0, 8'h3C, 0);
        tbl[22] = mk(0, 0,    0, 0,    8'h00, 0, 0,    0, 0, 0, 1, 8'h04, 0, 8'h3C, 0);
        tbl[23] = mk(0, 0,    1, 6400, 8'hAA, 0, 0,    1, 0, 0, 0, 8'h04, 0, 8'h3C, 0);
        tbl[24] = mk(0, 0,    0, 0,    8'h00, 1, 8191, 0, 1, 0, 0, 8'h04, 0, 8'h3C, 1);
        tbl[25] = mk(0, 0,    0, 0,    8'h00, 0, 0,    0, 0, 0, 0, 8'h04, 0, 8'h3C, 1);
        tbl[26] = mk(0, 0,    0, 0,    8'h00, 0, 0,    0, 0, 0, 0, 8'h04, 1, 8'h00, 1);

        // Power-on reset.
        rst_n = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk25);
        #1;
        @(negedge clk25);
        chk_all_zero("reset");
        next_cycle();
        rst_n = 1'b1;

        // Vector table, one row per clock.
        for (int i = 0; i < NV; i++) begin
            set_inputs(tbl[i].vr, tbl[i].va, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra);
            @(negedge clk25);
            chk($sformatf("row%0d hwr_ready", i),      32'(bus.hwr_ready), 32'(tbl[i].e_wrdy));
            chk($sformatf("row%0d hrd_ready", i),      32'(bus.hrd_ready), 32'(tbl[i].e_rrdy));
            chk($sformatf("row%0d ram_we", i),         32'(bus.ram_we), 32'(tbl[i].e_we));
            chk($sformatf("row%0d vid_valid", i),      32'(bus.vid_valid), 32'(tbl[i].e_vv));
            chk($sformatf("row%0d vid_data", i),       32'(bus.vid_data), 32'(tbl[i].e_vd));
            chk($sformatf("row%0d vid_miss", i),       32'(bus.vid_miss), 0);
            chk($sformatf("row%0d hrd_data_valid", i), 32'(bus.hrd_data_valid), 32'(tbl[i].e_hv));
            chk($sformatf("row%0d hrd_data", i),       32'(bus.hrd_data), 32'(tbl[i].e_hd));
            chk($sformatf("row%0d oob_err", i),        32'(bus.oob_err), 32'(tbl[i].e_oob));
            if (tbl[i].e_we) begin
                chk($sformatf("row%0d ram_addr", i),  32'(bus.ram_addr), 32'(tbl[i].wa));
                chk($sformatf("row%0d ram_wdata", i), 32'(bus.ram_wdata), 32'(tbl[i].wd));
            end
            next_cycle();
        end

        // Reset one cycle after a host read grant: the read must never report valid.
        set_inputs(0, 0, 0, 0, 0, 1, 5);
        @(negedge clk25);
        chk("midrst grant hrd_ready", 32'(bus.hrd_ready), 1);
        next_cycle();
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk25);
        chk("midrst cyc1 hrd_data_valid", 32'(bus.hrd_data_valid), 0);
        next_cycle();
        @(negedge clk25);
        chk_all_zero("midrst");
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk25);
            chk($sformatf("midrst post%0d hrd_data_valid", k), 32'(bus.hrd_data_valid), 0);
            chk($sformatf("midrst post%0d oob_err", k), 32'(bus.oob_err), 0);
            next_cycle();
        end

        // Video held on while a host write waits.
        begin
            logic       wr_done;
            logic [7:0] last_vd;
            logic       exp_rdy;
            logic       exp_miss;
            wr_done = 1'b0;
            last_vd = 8'h00;
            for (int i = 0; i < 40; i++) begin
                set_inputs(1, 13'(100 + i), !wr_done, 40, 8'h77, 0, 0);
                @(negedge clk25);
                exp_rdy = GUARD && (i == 15);
                chk($sformatf("starve c%0d hwr_ready", i), 32'(bus.hwr_ready), 32'(exp_rdy));
                chk($sformatf("starve c%0d ram_we", i),    32'(bus.ram_we), 32'(exp_rdy));
                if (i >= 2) begin
                    exp_miss = GUARD && (i == 17);
                    if (!exp_miss) last_vd = 8'(100 + i - 2);
                    chk($sformatf("starve c%0d vid_valid", i), 32'(bus.vid_valid), 1);
                    chk($sformatf("starve c%0d vid_miss", i),  32'(bus.vid_miss), 32'(exp_miss));
                    chk($sformatf("starve c%0d vid_data", i),  32'(bus.vid_data), 32'(last_vd));
                end else begin
                    chk($sformatf("starve c%0d vid_valid", i), 32'(bus.vid_valid), 0);
                end
                if (bus.hwr_ready) wr_done = 1'b1;
                next_cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port 8-bit pixel framebuffer RAM (13-bit address, 1-cycle read latency) between three requesters:
  - the video scan-out reader;
  - a host write port;
  - a host read port.
- Video has fixed priority because scan-out timing is not negotiable. The two host ports alternate round-robin in cycles video leaves free.
- Sits between the VGA timing/scan block, the host/blitter logic and the framebuffer RAM, all on clk25.

Parameters:
- AW, 13, framebuffer address width.
- DW, 8, pixel data width.
- FB_DEPTH, 6400, number of valid framebuffer locations; addresses >= FB_DEPTH are out of range.
- MAX_WAIT, 15, host wait-cycle limit used by the optional starvation guard (4-bit counter).

Ports:
- clk25  in  1  pixel clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- vid_req  in  1  video wants the RAM this cycle.
- vid_addr  in  AW  video read address.
- vid_data  out  DW  video read data.
- vid_valid  out  1  vid_data valid.
- vid_miss  out  1  video slot was pre-empted; vid_data holds the previous value.
- hwr_valid  in  1  host write request.
- hwr_ready  out  1  host write accepted this cycle.
- hwr_addr  in  AW  host write address.
- hwr_data  in  DW  host write data.
- hrd_valid  in  1  host read request.
- hrd_ready  out  1  host read accepted this cycle.
- hrd_addr  in  AW  host read address.
- hrd_data  out  DW  host read data.
- hrd_data_valid  out  1  hrd_data valid.
- oob_err  out  1  sticky: some request used an out-of-range address.
- ram_addr  out  AW  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid 1 cycle after the address.

Behaviour:
- Reset (rst_n=0 at the clock edge):
  - all outputs 0;
  - round-robin pointer set to write;
  - wait counter cleared;
  - in-flight read tag cleared.
- Reset takes priority over everything. A read in flight when reset is applied is discarded and produces no valid pulse.
- Grant is combinational each cycle, using GRANT_NONE / GRANT_VID / GRANT_WR / GRANT_RD:
  - vid_req=1 -> GRANT_VID;
  - otherwise, exactly one host request pending -> that host port;
  - otherwise, both host requests pending -> the port named by the round-robin pointer;
  - otherwise -> GRANT_NONE.
- Round-robin pointer: flips to the other host port after every host grant. It is unchanged on video grants and idle cycles.
- hwr_ready and hrd_ready are combinational and high only in their grant cycle. A host transfer completes when valid && ready.
- Host ports must hold valid, addr and data stable until ready. The arbiter does not buffer requests.
- RAM drive:
  - ram_addr is driven from the granted requester's address;
  - ram_we=1 only for GRANT_WR with an in-range address;
  - on idle cycles ram_addr holds its last value and ram_we=0.
- Read latency:
  - the registered tag {was_vid, was_hrd, oob} is captured in the grant cycle;
  - next cycle, vid_data/vid_valid or hrd_data/hrd_data_valid are registered from ram_rdata;
  - total latency is 2 cycles from grant to the valid output;
  - each valid is a 1-cycle pulse; data outputs hold between pulses.
- Out-of-range addresses (addr >= FB_DEPTH):
  - write: dropped (ram_we=0) but still acked;
  - read: returns 0 with valid asserted;
  - oob_err set to 1, cleared only by reset.
- Back-to-back operation: one grant per cycle and full throughput. A read followed by a write to the same address returns the old data.
- vid_miss is 0 whenever the starvation guard is compiled out.

Optional Feature:
- Macro: FB_STARVE_GUARD_EN.
- Defined:
  - 4-bit wait counter increments each cycle that any host request is pending and not granted;
  - clears on any host grant;
  - when the counter equals MAX_WAIT and vid_req=1, the host wins that cycle (normal round-robin choice);
  - vid_valid still pulses 2 cycles later, with vid_miss=1 and vid_data unchanged.
- Undefined:
  - counter absent and video is absolute priority;
  - hosts may starve indefinitely.

Decomposition:
- Shared package fb_pkg holds:
  - AW, DW, FB_DEPTH defaults;
  - grant enum {GRANT_NONE, GRANT_VID, GRANT_WR, GRANT_RD};
  - read-tag struct.
- One sub-module is natural: fb_rr_pick, the 2-way round-robin selector holding the pointer register.
- Read return path and OOB check stay in the top module.

Test Plan:
- Reset mid-read: hrd granted at addr 5, rst_n=0 the next cycle -> hrd_data_valid never pulses; all outputs 0 after reset.
- Video-only stream: vid_req=1 with addresses 0,1,2,... and RAM preloaded with mem[a]=a -> vid_valid continuous starting 2 cycles later, vid_data 0,1,2,...; host readies stay 0.
- Host contention with no video: hwr and hrd both held valid for 6 transfers -> grants alternate WR,RD,WR,RD,... starting with WR after reset; read of an address written earlier returns the written value.
- Out-of-range: write addr 6400 data 0xAA -> ram_we=0, hwr_ready=1, oob_err=1; read addr 8191 -> hrd_data=0 with valid pulse.
- Guard on: vid_req stuck at 1 while hwr_valid=1 -> hwr_ready at cycle 16 after request; vid_miss=1 two cycles later. Guard off -> hwr_ready never asserts.
- Back-to-back RAW: host read addr 10 then write addr 10 data 0x3C then read addr 10, with mem[10]=0x11 initially -> reads return 0x11, then 0x3C.
